// File: rtl/ram_copy_engine.sv
// ram_copy_engine: single-port RAM initiator that copies or fills word blocks.
// Ports: clk, resetb (sync, active-low); command start/mode/src_addr/dst_addr/
//   len/fill_data; status busy/done; RAM side ram_cs/ram_rnw/ram_address/
//   ram_din (registered outputs) and ram_dout (read data, one cycle latency).
module ram_copy_engine #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_data,
    output logic          busy,
    output logic          done,
    output logic          ram_cs,
    output logic          ram_rnw,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE, RD, CAP, WR, FILL, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   len_q, len_d;
    logic [DW-1:0] fill_q, fill_d;
    // Number of words whose write has already been issued.
    logic [AW:0]   cnt_q, cnt_d;

    logic          busy_d, done_d, cs_d, rnw_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] din_d;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_cs      <= 1'b0;
            ram_rnw     <= 1'b1;
            ram_address <= '0;
            ram_din     <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            busy        <= busy_d;
            done        <= done_d;
            ram_cs      <= cs_d;
            ram_rnw     <= rnw_d;
            ram_address <= addr_d;
            ram_din     <= din_d;
        end
    end

    // Outputs are computed for the state being entered and registered,
    // so each state's RAM signals appear during that state's cycle.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cs_d    = 1'b0;
        rnw_d   = 1'b1;
        addr_d  = ram_address;
        din_d   = ram_din;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = len;
                    fill_d = fill_data;
                    cnt_d  = '0;
                    if (len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (mode) begin
                        state_d = FILL;
                        busy_d  = 1'b1;
                        cs_d    = 1'b1;
                        rnw_d   = 1'b0;
                        addr_d  = dst_addr;
                        din_d   = fill_data;
                        cnt_d   = {{AW{1'b0}}, 1'b1};
                    end else begin
                        state_d = RD;
                        busy_d  = 1'b1;
                        cs_d    = 1'b1;
                        addr_d  = src_addr;
                    end
                end
            end
            RD: begin
                state_d = CAP;
                busy_d  = 1'b1;
            end
            CAP: begin
                // Read data is valid now; it becomes the write data of WR.
                state_d = WR;
                busy_d  = 1'b1;
                cs_d    = 1'b1;
                rnw_d   = 1'b0;
                addr_d  = dst_q + cnt_q[AW-1:0];
                din_d   = ram_dout;
                cnt_d   = cnt_q + 1'b1;
            end
            WR: begin
                if (cnt_q < len_q) begin
                    state_d = RD;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    addr_d  = src_q + cnt_q[AW-1:0];
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            FILL: begin
                if (cnt_q < len_q) begin
                    busy_d = 1'b1;
                    cs_d   = 1'b1;
                    rnw_d  = 1'b0;
                    addr_d = dst_q + cnt_q[AW-1:0];
                    din_d  = fill_q;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: bench for ram_copy_engine with a behavioural 4096x32
// RAM, an access scoreboard and a reference memory image.
module tb_ram_copy_engine;

    logic        clk = 1'b0;
    logic        resetb;
    logic        start;
    logic        mode;
    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [12:0] len;
    logic [31:0] fill_data;
    logic        busy;
    logic        done;
    logic        ram_cs;
    logic        ram_rnw;
    logic [11:0] ram_address;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    ram_copy_engine #(.AW(12), .DW(32)) dut (
        .clk(clk), .resetb(resetb), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .busy(busy), .done(done),
        .ram_cs(ram_cs), .ram_rnw(ram_rnw), .ram_address(ram_address),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input bit ok,
                       input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // RAM model: address/data latched on the edge, write committed one
    // edge later, read data valid the cycle after the read.
    logic [31:0] mem [4096];
    logic [31:0] refm [4096];
    logic        pend_wr = 1'b0;
    logic [11:0] pend_addr;
    logic [31:0] pend_data;

    always @(posedge clk) begin
        if (pend_wr) mem[pend_addr] <= pend_data;
        pend_wr   <= ram_cs && !ram_rnw;
        pend_addr <= ram_address;
        pend_data <= ram_din;
        if (ram_cs && ram_rnw)
            ram_dout <= (pend_wr && pend_addr == ram_address) ?
                        pend_data : mem[ram_address];
    end

    typedef struct {
        logic        rnw;
        logic [11:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t q[$];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ram_cs) begin
            if (q.size() == 0) begin
                chk("unexpected_access", 1'b0,
                    longint'({ram_rnw, ram_address, ram_din}), 0);
            end else begin
                acc_t e;
                logic [31:0] ad;
                logic [31:0] ed;
                e = q.pop_front();
                ad = ram_rnw ? 32'h0 : ram_din;
                ed = e.rnw ? 32'h0 : e.data;
                chk("ram_access",
                    ram_rnw == e.rnw && ram_address == e.addr && ad == ed,
                    longint'({ram_rnw, ram_address, ad}),
                    longint'({e.rnw, e.addr, ed}));
            end
        end
    end

    function automatic void push(input logic r, input logic [11:0] a,
                                 input logic [31:0] d);
        acc_t e;
        e.rnw = r;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endfunction

    task automatic check_mem(input string name);
        int nbad;
        int first;
        @(posedge clk);
        #1;
        nbad = 0;
        first = 0;
        for (int i = 0; i < 4096; i++) begin
            if (mem[i] !== refm[i]) begin
                if (nbad == 0) first = i;
                nbad++;
            end
        end
        chk(name, nbad == 0, longint'(mem[first]), longint'(refm[first]));
    endtask

    task automatic run_cmd(input logic m, input logic [11:0] s,
                           input logic [11:0] d, input logic [12:0] n,
                           input logic [31:0] f, input int exp,
                           input int inject);
        int cyc;
        int lim;
        int pre;
        for (int i = 0; i < int'(n); i++) begin
            logic [11:0] sa;
            logic [11:0] da;
            sa = s + 12'(i);
            da = d + 12'(i);
            if (m) begin
                push(1'b0, da, f);
                refm[da] = f;
            end else begin
                push(1'b1, sa, 32'h0);
                push(1'b0, da, refm[sa]);
                refm[da] = refm[sa];
            end
        end
        @(negedge clk);
        mode = m;
        src_addr = s;
        dst_addr = d;
        len = n;
        fill_data = f;
        start = 1'b1;
        pre = done_cnt;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        if (n != 0) chk("busy_first", busy == 1'b1, longint'(busy), 1);
        lim = 3 * int'(n) + 10;
        while (!done && cyc < lim) begin
            if (cyc == inject) begin
                start = 1'b1;
                mode = 1'b0;
                src_addr = 12'h000;
                dst_addr = 12'h700;
                len = 13'd5;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("done_cycle", done && cyc == exp, longint'(cyc), longint'(exp));
        chk("idle_at_done", !busy && !ram_cs && ram_rnw,
            longint'({busy, ram_cs, ram_rnw}), 1);
        #1;
        chk("done_pulses", done_cnt == pre + 1,
            longint'(done_cnt - pre), 1);
        chk("queue_drained", q.size() == 0, longint'(q.size()), 0);
    endtask

    typedef struct {
        logic        m;
        logic [11:0] s;
        logic [11:0] d;
        logic [12:0] n;
        logic [31:0] f;
        int          exp;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int pre;
        vecs[0] = '{1'b1, 12'h000, 12'h010, 13'd4, 32'hDEADBEEF, 5};
        vecs[1] = '{1'b0, 12'h000, 12'h100, 13'd3, 32'h0, 10};
        vecs[2] = '{1'b1, 12'h000, 12'hFFE, 13'd3, 32'hA5A5A5A5, 4};
        vecs[3] = '{1'b1, 12'h000, 12'h020, 13'd0, 32'h77777777, 1};
        vecs[4] = '{1'b0, 12'h000, 12'h030, 13'd0, 32'h0, 1};
        vecs[5] = '{1'b0, 12'h200, 12'h201, 13'd4, 32'h0, 13};
        vecs[6] = '{1'b0, 12'hFFF, 12'h7FE, 13'd3, 32'h0, 10};
        vecs[7] = '{1'b1, 12'h000, 12'h000, 13'd4096, 32'h5A5A0F0F, 4097};

        for (int i = 0; i < 4096; i++) begin
            mem[i] <= 32'(i) * 32'h9E3779B1;
            refm[i] = 32'(i) * 32'h9E3779B1;
        end
        mem[0] <= 32'h11111111;
        mem[1] <= 32'h22222222;
        mem[2] <= 32'h33333333;
        refm[0] = 32'h11111111;
        refm[1] = 32'h22222222;
        refm[2] = 32'h33333333;

        resetb = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len = '0;
        fill_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy == 1'b0, longint'(busy), 0);
        chk("rst_done", done == 1'b0, longint'(done), 0);
        chk("rst_cs", ram_cs == 1'b0, longint'(ram_cs), 0);
        chk("rst_rnw", ram_rnw == 1'b1, longint'(ram_rnw), 1);
        chk("rst_addr", ram_address == 12'h0, longint'(ram_address), 0);
        chk("rst_din", ram_din == 32'h0, longint'(ram_din), 0);
        resetb = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].m, vecs[i].s, vecs[i].d, vecs[i].n,
                    vecs[i].f, vecs[i].exp, 0);
            check_mem($sformatf("mem_vec%0d", i));
        end

        // Start during a fill is dropped; next start right after DONE works.
        run_cmd(1'b1, 12'h000, 12'h500, 13'd8, 32'h12345678, 9, 3);
        run_cmd(1'b1, 12'h000, 12'h600, 13'd2, 32'h0BADF00D, 3, 0);
        check_mem("mem_busy_start");

        // Reset during the second word's CAP of a 3-word copy.
        push(1'b1, 12'h300, 32'h0);
        push(1'b0, 12'h400, refm[12'h300]);
        push(1'b1, 12'h301, 32'h0);
        refm[12'h400] = refm[12'h300];
        @(negedge clk);
        mode = 1'b0;
        src_addr = 12'h300;
        dst_addr = 12'h400;
        len = 13'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        chk("rst_mid_cs", ram_cs == 1'b0, longint'(ram_cs), 0);
        chk("rst_mid_rnw", ram_rnw == 1'b1, longint'(ram_rnw), 1);
        chk("rst_mid_busy", busy == 1'b0, longint'(busy), 0);
        chk("rst_mid_done", done == 1'b0, longint'(done), 0);
        resetb = 1'b1;
        pre = done_cnt;
        repeat (20) @(negedge clk);
        #1;
        chk("rst_mid_no_done", done_cnt == pre, longint'(done_cnt - pre), 0);
        chk("rst_mid_queue", q.size() == 0, longint'(q.size()), 0);
        check_mem("mem_rst_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_copy_engine.md
# ram_copy_engine

Single-port RAM initiator that moves or fills blocks of 32-bit words through the registered-address, synchronous-write RAM port used by the 4096x32 memory. It accepts one command at a time (copy or fill), sequences the RAM chip-select, read/write, address and write-data lines itself, and reports completion with a one-cycle pulse. It sits between the control logic and the RAM as the only master on that port while busy.

## Interface
- AW, 12, RAM address width; all address arithmetic wraps modulo 2^AW
- DW, 32, RAM data width
- clk  in  1  clock; all state changes on rising edge
- resetb  in  1  reset, synchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  AW  copy source base (ignored in fill)
- dst_addr  in  AW  destination base
- len  in  AW+1  word count, 0..2^AW
- fill_data  in  DW  fill pattern (ignored in copy)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- ram_cs  out  1  RAM chip select
- ram_rnw  out  1  1 = read, 0 = write
- ram_address  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data, valid the cycle after a read is presented

## Operation
- All outputs are driven directly from flops; no combinational paths from inputs to outputs.
- Reset values: busy=0, done=0, ram_cs=0, ram_rnw=1, ram_address=0, ram_din=0; state IDLE; internal counters 0.
- States: IDLE, RD, CAP, WR, FILL, DONE.
- IDLE: on start=1, latch src/dst/len/mode/fill_data. len=0 -> DONE. mode=1 -> FILL. mode=0 -> RD. start=0 -> stay.
- RD: ram_cs=1, ram_rnw=1, ram_address=src+i. Next CAP.
- CAP: ram_cs=0, ram_rnw=1; capture ram_dout into data register at end of cycle. Next WR.
- WR: ram_cs=1, ram_rnw=0, ram_address=dst+i, ram_din=captured word; i++. Next RD if i<len, else DONE.
- FILL: ram_cs=1, ram_rnw=0, ram_address=dst+i, ram_din=fill_data; i++. Stay while i<len, else DONE.
- DONE: done=1, busy=0, ram_cs=0, ram_rnw=1. Next IDLE unconditionally.
- busy=1 in every RD/CAP/WR/FILL cycle, 0 in IDLE and DONE.
- Address wrap: src+i and dst+i are computed modulo 2^AW (0xFFF+1 -> 0x000).
- Copy always ascends. For overlapping ranges with dst>src, later reads return already-written words (forward propagation). This is the defined behaviour; memmove semantics are not provided.
- start while busy or in DONE is ignored; it is not queued.
- Reset mid-command: at the next rising edge with resetb=0, all outputs take reset values and the state returns to IDLE. No further RAM access is issued. A write presented in the same cycle that reset is sampled is still latched by the RAM.

## Timing
- start sampled at edge E in IDLE. The first RD/FILL cycle is E+1. For len=0, done=1 in E+1.
- Copy: 3 cycles per word; done asserted in cycle E+1+3*len.
- Fill: 1 cycle per word, ram_cs held high for len consecutive cycles; done asserted in cycle E+1+len.
- Read latency: the RAM latches the address at the end of RD; ram_dout is valid in CAP and is sampled at the end of CAP.
- The RAM commits each write one edge after latching it. The final write is therefore in memory at the end of the DONE cycle, and any read presented from the cycle after DONE returns the new data.
- Earliest next command: start in the first IDLE cycle after DONE.

## Test plan
- Fill: dst=0x010, len=4, fill_data=0xDEADBEEF -> ram_cs=1, rnw=0 for 4 consecutive cycles at 0x010..0x013, done in the 5th cycle after start; readback of all 4 words = 0xDEADBEEF.
- Copy: preload 0x000..0x002 = 0x11111111/0x22222222/0x33333333; copy src=0x000, dst=0x100, len=3 -> RD/CAP/WR pattern with ram_cs low every CAP cycle, done 10 cycles after start; 0x100..0x102 match the source.
- Wrap: fill dst=0xFFE, len=3, data=0xA5A5A5A5 -> addresses 0xFFE, 0xFFF, 0x000 in order; 0x001 unchanged.
- Zero length and full length: len=0 -> done next cycle with no ram_cs activity. len=4096 fill -> ram_cs high 4096 cycles covering every address once, done on cycle 4097.
- Reset mid-copy: resetb=0 during the 2nd word's CAP -> next cycle ram_cs=0, ram_rnw=1, busy=0, done never pulses; only word 0 is written at dst.
- Start while busy: a second start during a len=8 fill is ignored -> exactly 8 writes and one done pulse; new start in IDLE after DONE is accepted.
